// File: rtl/hifq_tap_sequencer.sv
// hifq_tap_sequencer
//   Read-side controller for the high-frequency circular sample queue.
//   Every accepted sample starts one burst of TAPS read addresses. The burst
//   begins at the oldest sample and wraps at DEPTH. The coefficient ROM
//   address runs in lockstep with it. The block also produces the framing
//   strobes for the downstream FIR multiply-accumulate.
//
//   Optional feature macro: HIFQ_PEND_EN
//     When defined, one request that arrives during a burst is held as
//     pending. It is started straight from the FLUSH cycle.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   wrt_smpl    in   single-cycle strobe: new sample written to queue
//   q_ready     in   queue holds a full window (level)
//   old_ptr     in   address of oldest sample, sampled on accept
//   clr_ovr     in   synchronous clear of ovr
//   raddr       out  queue RAM read address
//   coeff_addr  out  coefficient ROM address (0..TAPS-1)
//   dat_vld     out  RAM/ROM data valid (one cycle after address)
//   first       out  with dat_vld: tap 0
//   last        out  with dat_vld: tap TAPS-1
//   busy        out  burst in progress
//   done        out  single-cycle pulse: burst complete
//   ovr         out  sticky: request lost
module hifq_tap_sequencer #(
    parameter int DEPTH = 1536,
    parameter int TAPS  = 1021,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrt_smpl,
    input  logic          q_ready,
    input  logic [AW-1:0] old_ptr,
    input  logic          clr_ovr,
    output logic [AW-1:0] raddr,
    output logic [AW-1:0] coeff_addr,
    output logic          dat_vld,
    output logic          first,
    output logic          last,
    output logic          busy,
    output logic          done,
    output logic          ovr
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [AW-1:0] LAST_IDX  = AW'(TAPS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          vld_q, first_q, last_q, ovr_q;
    logic          vld_d, first_d, last_d, ovr_d;

    logic req, accept, last_issue, load, restart, ovr_set;

    assign req        = wrt_smpl & q_ready;
    assign accept     = req && (state_q == IDLE);
    assign last_issue = (state_q == RUN) && (idx_q == LAST_IDX);
    assign load       = accept || restart;

`ifdef HIFQ_PEND_EN
    logic pend_q, pend_d;

    // A request that lands in FLUSH itself restarts directly.
    // This is the same as setting pend and consuming it in the same cycle.
    assign restart = (state_q == FLUSH) && (pend_q || req);
    assign ovr_set = req && busy && pend_q;

    always_comb begin
        pend_d = pend_q;
        if (state_q == FLUSH)
            pend_d = 1'b0;
        else if (req && busy)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end
`else
    assign restart = 1'b0;
    assign ovr_set = req && busy;
`endif

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_issue) state_d = FLUSH;
            FLUSH:   state_d = restart ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FLUSH);
    end

    // ---- Address / framing datapath ----
    always_comb begin
        raddr_d = raddr_q;
        idx_d   = idx_q;
        if (load) begin
            raddr_d = old_ptr;
            idx_d   = '0;
        end else if ((state_q == RUN) && !last_issue) begin
            // Wrap by compare so raddr never reaches DEPTH.
            raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
            idx_d   = idx_q + 1'b1;
        end
        // Framing flags follow the address by the RAM read latency.
        vld_d   = (state_q == RUN);
        first_d = (state_q == RUN) && (idx_q == '0);
        last_d  = last_issue;
        ovr_d   = ovr_set | (ovr_q & ~clr_ovr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            raddr_q <= raddr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
        end
    end

    assign raddr      = raddr_q;
    assign coeff_addr = idx_q;
    assign dat_vld    = vld_q;
    assign first      = first_q;
    assign last       = last_q;
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_hifq_tap_sequencer.sv
// Bench for hifq_tap_sequencer.
// Three instances are used:
//   - the full-size configuration (1536/1021), driven by hand-written burst sequences;
//   - a small configuration (8/8), driven from a vector table;
//   - a TAPS=1 configuration, checked for the single-tap boundary.
module tb_hifq_tap_sequencer;

    localparam int D = 1536;
    localparam int T = 1021;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // full-size instance
    logic        b_wrt, b_qr, b_clr;
    logic [10:0] b_ptr, b_raddr, b_coeff;
    logic        b_vld, b_first, b_last, b_busy, b_done, b_ovr;

    hifq_tap_sequencer #(.DEPTH(D), .TAPS(T), .AW(11)) u_big (
        .clk(clk), .rst(rst), .wrt_smpl(b_wrt), .q_ready(b_qr), .old_ptr(b_ptr),
        .clr_ovr(b_clr), .raddr(b_raddr), .coeff_addr(b_coeff), .dat_vld(b_vld),
        .first(b_first), .last(b_last), .busy(b_busy), .done(b_done), .ovr(b_ovr)
    );

    // small instance, DEPTH=8 TAPS=8
    logic       s_wrt, s_qr, s_clr;
    logic [2:0] s_ptr, s_raddr, s_coeff;
    logic       s_vld, s_first, s_last, s_busy, s_done, s_ovr;

    hifq_tap_sequencer #(.DEPTH(8), .TAPS(8), .AW(3)) u_small (
        .clk(clk), .rst(rst), .wrt_smpl(s_wrt), .q_ready(s_qr), .old_ptr(s_ptr),
        .clr_ovr(s_clr), .raddr(s_raddr), .coeff_addr(s_coeff), .dat_vld(s_vld),
        .first(s_first), .last(s_last), .busy(s_busy), .done(s_done), .ovr(s_ovr)
    );

    // single-tap instance
    logic       t_wrt, t_qr, t_clr;
    logic [2:0] t_ptr, t_raddr, t_coeff;
    logic       t_vld, t_first, t_last, t_busy, t_done, t_ovr;

    hifq_tap_sequencer #(.DEPTH(8), .TAPS(1), .AW(3)) u_one (
        .clk(clk), .rst(rst), .wrt_smpl(t_wrt), .q_ready(t_qr), .old_ptr(t_ptr),
        .clr_ovr(t_clr), .raddr(t_raddr), .coeff_addr(t_coeff), .dat_vld(t_vld),
        .first(t_first), .last(t_last), .busy(t_busy), .done(t_done), .ovr(t_ovr)
    );

    typedef struct {
        logic       wrt, qr, clr;
        logic [2:0] ptr;
        logic [2:0] raddr, coeff;
        logic [5:0] fl;   // {dat_vld, first, last, busy, done, ovr}
    } vec_t;

    vec_t tbl [15];

    int   n_err = 0;
    int   n_chk = 0;
    logic ovr_m, pend_m;

    function automatic vec_t mk(input logic w, input logic q, input logic c,
                                input logic [2:0] p, input logic [2:0] ra,
                                input logic [2:0] co, input logic [5:0] fl);
        vec_t v;
        v.wrt = w; v.qr = q; v.clr = c; v.ptr = p;
        v.raddr = ra; v.coeff = co; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    function automatic logic [27:0] big_pack();
        return {b_raddr, b_coeff, b_vld, b_first, b_last, b_busy, b_done, b_ovr};
    endfunction

    // Runs one full-size burst, checking every cycle from T+1 to T+TAPS+1.
    //   s2/s3: cycle offsets of extra strobes.
    //   clr:   cycle offset of clr_ovr.
    //   nxt:   old_ptr presented in the FLUSH cycle.
    //   acc:   drive the accepting strobe in the current cycle.
    //   rs:    returns 1 if the bench model expects an immediate restart.
    task automatic big_burst(input int start, input int s2, input int s3, input int clr,
                             input int nxt, input bit acc, output bit rs);
        int          a, ix;
        logic        set;
        logic [27:0] e;
        if (acc) begin
            b_wrt = 1'b1; b_qr = 1'b1; b_ptr = 11'(start);
        end
        rs = 1'b0;
        for (int k = 1; k <= T + 1; k++) begin
            step;
            ix = (k <= T) ? k - 1 : T - 1;
            a  = (start + ix) % D;
            e  = {a[10:0], ix[10:0], 1'(k >= 2), 1'(k == 2), 1'(k == T + 1), 1'b1,
                  1'(k == T + 1), ovr_m};
            chk($sformatf("burst%0d k=%0d", start, k), 32'(big_pack()), 32'(e));
            b_wrt = (k == s2) || (k == s3);
            b_clr = (k == clr);
            b_ptr = (k == T + 1) ? 11'(nxt) : 11'(k % D);
            set   = 1'b0;
            if (b_wrt) begin
`ifdef HIFQ_PEND_EN
                if (pend_m) set = 1'b1;
                else        pend_m = 1'b1;
`else
                set = 1'b1;
`endif
            end
            ovr_m = set | (ovr_m & ~b_clr);
            if (k == T + 1) begin
                rs     = pend_m;
                pend_m = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input string nm, input int ra, input int co);
        logic [27:0] e;
        step;
        e = {11'(ra), 11'(co), 5'b00000, ovr_m};
        chk(nm, 32'(big_pack()), 32'(e));
        b_wrt = 1'b0; b_clr = 1'b0;
    endtask

    initial begin
        bit rs;
        int nd;
        rst = 1'b1;
        b_wrt = 0; b_qr = 0; b_clr = 0; b_ptr = '0;
        s_wrt = 0; s_qr = 0; s_clr = 0; s_ptr = '0;
        t_wrt = 0; t_qr = 0; t_clr = 0; t_ptr = '0;
        ovr_m = 1'b0; pend_m = 1'b0;

        // small configuration: gating, wrap 5..4, back-to-back accepts 10 cycles apart
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 6'b000000);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 6'b000000);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 3'd0, 6'b000000);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd5, 3'd0, 6'b000100);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd6, 3'd1, 6'b110100);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd7, 3'd2, 6'b100100);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd0, 3'd3, 6'b100100);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd1, 3'd4, 6'b100100);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 3'd5, 6'b100100);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd3, 3'd6, 6'b100100);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd4, 3'd7, 6'b100100);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 3'd2, 3'd4, 3'd7, 6'b101110);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 3'd3, 3'd4, 3'd7, 6'b000000);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 3'd0, 3'd3, 3'd0, 6'b000100);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 3'd1, 6'b110100);

        // reset state
        repeat (2) step;
        chk("reset big", 32'(big_pack()), 32'd0);
        chk("reset small", 32'({s_raddr, s_coeff, s_vld, s_first, s_last, s_busy, s_done, s_ovr}), 32'd0);
        rst = 1'b0;
        step;
        chk("post-reset big", 32'(big_pack()), 32'd0);

        for (int i = 0; i < 15; i++) begin
            step;
            chk($sformatf("small row %0d", i),
                32'({s_raddr, s_coeff, s_vld, s_first, s_last, s_busy, s_done, s_ovr}),
                32'({tbl[i].raddr, tbl[i].coeff, tbl[i].fl}));
            s_wrt = tbl[i].wrt; s_qr = tbl[i].qr; s_clr = tbl[i].clr; s_ptr = tbl[i].ptr;
        end

        // TAPS=1: first and last together
        t_wrt = 1'b1; t_qr = 1'b1; t_ptr = 3'd6;
        step;
        t_wrt = 1'b0;
        chk("one addr", 32'({t_raddr, t_coeff, t_vld, t_first, t_last, t_busy, t_done, t_ovr}), 32'({3'd6, 3'd0, 6'b000100}));
        step;
        chk("one data", 32'({t_raddr, t_coeff, t_vld, t_first, t_last, t_busy, t_done, t_ovr}), 32'({3'd6, 3'd0, 6'b111110}));
        step;
        chk("one idle", 32'({t_raddr, t_coeff, t_vld, t_first, t_last, t_busy, t_done, t_ovr}), 32'({3'd6, 3'd0, 6'b000000}));

        // gating: strobe without q_ready is ignored
        step;
        b_wrt = 1'b1; b_qr = 1'b0;
        step;
        chk("gated", 32'(big_pack()), 32'd0);

        // basic burst from 100
        big_burst(100, 0, 0, 0, 0, 1'b1, rs);
        idle_check("idle after 100", 1120, 1020);

        // wrap from 1530, overrun strobes at 500/550, clear at 600
        big_burst(1530, 500, 550, 600, 200, 1'b1, rs);
        if (rs) begin
            big_burst(200, 0, 0, 0, 0, 1'b0, rs);
            idle_check("idle after pend", 1220, 1020);
        end else begin
            idle_check("idle after wrap", 1014, 1020);
        end

        // set wins over clear in the same cycle
        big_burst(0, 10, 20, 20, 300, 1'b1, rs);
        if (rs) begin
            big_burst(300, 0, 0, 0, 0, 1'b0, rs);
            idle_check("idle after pend2", 1320, 1020);
        end else begin
            idle_check("idle after setwin", 1020, 1020);
        end
        chk("ovr sticky", 32'(b_ovr), 32'd1);

        // asynchronous reset in the middle of a burst (idx=500)
        b_wrt = 1'b1; b_qr = 1'b1; b_ptr = 11'd300;
        step;
        b_wrt = 1'b0;
        repeat (500) step;
        chk("mid-run addr", 32'({b_raddr, b_coeff, b_busy}), 32'({11'd800, 11'd500, 1'b1}));
        #1 rst = 1'b1;
        #1 chk("async reset", 32'(big_pack()), 32'd0);
        ovr_m = 1'b0;
        step;
        rst = 1'b0;
        nd = 0;
        repeat (1100) begin
            step;
            if (b_done || b_busy) nd++;
        end
        chk("no done after reset", 32'(nd), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hifq_tap_sequencer.md
Name: hifq_tap_sequencer

Overview:
- Read-side controller for the high-frequency circular sample queue (dual-port 1536x16 RAM).
- On each accepted new sample, issues one burst of TAPS consecutive read addresses, starting at the oldest sample and wrapping at DEPTH.
- Drives the coefficient ROM address in lockstep and produces framing strobes for the downstream FIR multiply-accumulate.
- Sits between the queue write logic (wrt_smpl, full/sequencing flag, oldest pointer) and the FIR datapath.

Parameters:
DEPTH, 1536, number of queue entries; addresses 0..DEPTH-1
TAPS, 1021, reads per burst (filter length); 1 <= TAPS <= DEPTH
AW, 11, address width; 2**AW >= DEPTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wrt_smpl  in  1  single-cycle strobe in clk domain: new sample written to queue
q_ready  in  1  queue holds a full window (sequencing); level
old_ptr  in  AW  address of oldest sample; sampled on accept
clr_ovr  in  1  synchronous clear of ovr
raddr  out  AW  queue RAM read address
coeff_addr  out  AW  coefficient ROM address (0..TAPS-1)
dat_vld  out  1  RAM/ROM data valid this cycle (1 cycle after address)
first  out  1  with dat_vld: tap 0 (MAC clears accumulator)
last  out  1  with dat_vld: tap TAPS-1
busy  out  1  burst in progress
done  out  1  single-cycle pulse: burst complete, accumulator final
ovr  out  1  sticky: request lost

Behaviour:
- Reset (async, any state): state=IDLE; raddr=0, coeff_addr=0, dat_vld=0, first=0, last=0, busy=0, done=0, ovr=0; any in-progress burst is abandoned, no done.
- Accept: wrt_smpl=1 and q_ready=1 in IDLE -> capture start=old_ptr, idx=0, go RUN next cycle.
- wrt_smpl with q_ready=0 is ignored; ovr not set.
- States:
  - IDLE: busy=0; address outputs hold their last values.
  - RUN: busy=1; each cycle raddr=start+idx mod DEPTH, coeff_addr=idx, idx++. After idx=TAPS-1 is issued -> FLUSH.
  - FLUSH: busy=1, one cycle; last data returns; done pulses this cycle; -> IDLE. Next accept is possible in the following cycle.
- Wrap: raddr increments and goes DEPTH-1 -> 0, never reaching DEPTH. Wrap is realised by compare, not modulo arithmetic.
- Latency:
  - Accept cycle T; first address at T+1; dat_vld/first at T+2.
  - Last address at T+TAPS; dat_vld/last/done at T+TAPS+1; busy high T+1..T+TAPS+1.
  - Burst spacing: >= TAPS+2 cycles.
- dat_vld is the issue flag registered by 1 cycle (RAM read latency = 1). first and last are registered alongside it and qualified by it.
- TAPS=1: first and last are asserted in the same cycle.
- Overrun: wrt_smpl=1, q_ready=1 while busy -> request dropped, ovr=1 (sticky).
- clr_ovr=1 clears ovr. If an overrun and clr_ovr occur in the same cycle, set wins.
- old_ptr changes during a burst have no effect; start is latched.

Optional Feature:
HIFQ_PEND_EN
- Defined: one-deep pending flag. A request arriving while busy sets pend, and ovr stays clear. On the FLUSH cycle with pend=1: pend clears, start=old_ptr is sampled, and state goes straight to RUN (no IDLE cycle; busy stays 1). A second request while pend=1 sets ovr. Reset clears pend.
- Undefined: no pend register; behaviour exactly as in Behaviour.

Test Plan:
- Reset: assert rst mid-RUN (DEPTH=1536, TAPS=1021, idx=500) -> same-cycle busy=0, dat_vld=0, ovr=0; no done follows.
- Basic burst: q_ready=1, old_ptr=100, wrt_smpl at T -> raddr 100..1120 on T+1..T+1021; first at T+2; last+done at T+1022; busy drops T+1023.
- Wrap: old_ptr=1530 -> raddr 1530..1535, 0, 1, ..., 1014; coeff_addr 0..1020; never 1536.
- Gating: wrt_smpl with q_ready=0 -> busy stays 0, ovr=0. Then q_ready=1 and wrt_smpl -> burst starts next cycle.
- Overrun: second wrt_smpl at T+500 -> ovr=1, only one done. clr_ovr at T+600 -> ovr=0. With HIFQ_PEND_EN: second burst starts at T+1022 with no gap and ovr=0. A third strobe at T+600 -> ovr=1.
- Small config DEPTH=8, TAPS=8, old_ptr=5 -> raddr 5,6,7,0,1,2,3,4; back-to-back accepts every 10 cycles produce no ovr.
